// File: rtl/maxnet_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// maxnet_pkg : shared types and constants for the MaxNet sequencer/datapath
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package maxnet_pkg;

  localparam int N      = 4;
  localparam int ADDR_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CHECK  = 3'd2,
    CLR    = 3'd3,
    MAC    = 3'd4,
    WR     = 3'd5,
    COMMIT = 3'd6,
    DONE   = 3'd7
  } state_e;

  // Q2.3 weights: diagonal is +1.0, off-diagonal is -epsilon (-0.25)
  localparam logic [4:0] W_ONE       = 5'b01000;
  localparam logic [4:0] W_MINUS_EPS = 5'b11110;

endpackage

`default_nettype wire

// File: rtl/maxnet_sequencer_if.sv
// ---------------------------------------------------------------------------
// maxnet_sequencer_if : control/status bundle between top level and sequencer
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface maxnet_sequencer_if
  import maxnet_pkg::*;
#(
  parameter int ITER_W = 4
) ();

  logic              start;
  logic [N-1:0]      pos_flags;
  logic              in_ld;
  logic              acc_clr;
  logic              acc_en;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        x_sel;
  logic [N-1:0]      res_ld;
  logic              commit;
  logic              busy;
  logic              done;
  logic [1:0]        winner;
  logic              winner_vld;
  logic              timeout;
  logic [ITER_W-1:0] iter_cnt;

  modport master (
    output start, pos_flags,
    input  in_ld, acc_clr, acc_en, w_addr, x_sel, res_ld, commit,
           busy, done, winner, winner_vld, timeout, iter_cnt
  );

  modport slave (
    input  start, pos_flags,
    output in_ld, acc_clr, acc_en, w_addr, x_sel, res_ld, commit,
           busy, done, winner, winner_vld, timeout, iter_cnt
  );

endinterface

`default_nettype wire

// File: rtl/maxnet_sequencer_pos_resolve4.sv
// ---------------------------------------------------------------------------
// pos_resolve4 : popcount <= 1 test plus index encoder of the positive flags
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pos_resolve4 (
  input  logic [3:0] flags_i,
  output logic       le_one_o,
  output logic [1:0] idx_o
);

  logic [2:0] w_cnt;

  assign w_cnt = {2'b00, flags_i[0]} + {2'b00, flags_i[1]}
               + {2'b00, flags_i[2]} + {2'b00, flags_i[3]};

  assign le_one_o = (w_cnt <= 3'd1);

  // Only meaningful when at most one flag is set; lowest index wins otherwise
  always_comb begin
    idx_o = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (flags_i[i]) begin
        idx_o = i[1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/maxnet_sequencer.sv
// ---------------------------------------------------------------------------
// maxnet_sequencer : control FSM stepping the 4-neuron MaxNet datapath
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module maxnet_sequencer
  import maxnet_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_ITER = 15,
  parameter int ITER_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  maxnet_sequencer_if.slave  bus
);

  localparam logic [1:0]   LAST_IDX = 2'(N - 1);
  localparam logic [N-1:0] ONE_HOT0 = N'(1);

  state_e            state_q, state_d;
  logic [1:0]        row_q, row_d;
  logic [1:0]        col_q, col_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [1:0]        winner_q, winner_d;
  logic              wvld_q, wvld_d;
  logic              tmo_q, tmo_d;

  logic              in_ld_q, acc_clr_q, acc_en_q, commit_q, busy_q, done_q;
  logic [3:0]        w_addr_q;
  logic [1:0]        x_sel_q;
  logic [N-1:0]      res_ld_q;

  logic              w_le_one;
  logic [1:0]        w_idx;

  pos_resolve4 u_resolve (
    .flags_i  (bus.pos_flags),
    .le_one_o (w_le_one),
    .idx_o    (w_idx)
  );

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    iter_d   = iter_q;
    winner_d = winner_q;
    wvld_d   = wvld_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = LOAD;
          iter_d   = '0;
          winner_d = 2'd0;
          wvld_d   = 1'b0;
          tmo_d    = 1'b0;
        end
      end
      LOAD:  state_d = CHECK;
      CLR: begin
        state_d = MAC;
        col_d   = 2'd0;
      end
      MAC: begin
        if (col_q == LAST_IDX) begin
          state_d = WR;
          col_d   = 2'd0;
        end else begin
          col_d = col_q + 2'd1;
        end
      end
      WR: begin
        if (row_q == LAST_IDX) begin
          state_d = COMMIT;
          row_d   = 2'd0;
        end else begin
          state_d = CLR;
          row_d   = row_q + 2'd1;
        end
      end
      COMMIT: begin
        state_d = CHECK;
        iter_d  = iter_q + ITER_W'(1);
      end
      CHECK: begin
        if (w_le_one) begin
          state_d  = DONE;
          winner_d = w_idx;
          wvld_d   = |bus.pos_flags;
        end else if (iter_q == ITER_W'(MAX_ITER)) begin
          state_d = DONE;
          tmo_d   = 1'b1;
          wvld_d  = 1'b0;
        end else begin
          state_d = CLR;
          row_d   = 2'd0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they line up with state_q
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_q     <= 2'd0;
      col_q     <= 2'd0;
      iter_q    <= '0;
      winner_q  <= 2'd0;
      wvld_q    <= 1'b0;
      tmo_q     <= 1'b0;
      in_ld_q   <= 1'b0;
      acc_clr_q <= 1'b0;
      acc_en_q  <= 1'b0;
      w_addr_q  <= 4'd0;
      x_sel_q   <= 2'd0;
      res_ld_q  <= '0;
      commit_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      iter_q    <= iter_d;
      winner_q  <= winner_d;
      wvld_q    <= wvld_d;
      tmo_q     <= tmo_d;
      in_ld_q   <= (state_d == LOAD);
      acc_clr_q <= (state_d == CLR);
      acc_en_q  <= (state_d == MAC);
      w_addr_q  <= (state_d == MAC) ? {row_d, col_d} : 4'd0;
      x_sel_q   <= (state_d == MAC) ? col_d : 2'd0;
      res_ld_q  <= (state_d == WR) ? (ONE_HOT0 << row_d) : '0;
      commit_q  <= (state_d == COMMIT);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
    end
  end

  assign bus.in_ld      = in_ld_q;
  assign bus.acc_clr    = acc_clr_q;
  assign bus.acc_en     = acc_en_q;
  assign bus.w_addr     = w_addr_q;
  assign bus.x_sel      = x_sel_q;
  assign bus.res_ld     = res_ld_q;
  assign bus.commit     = commit_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.winner     = winner_q;
  assign bus.winner_vld = wvld_q;
  assign bus.timeout    = tmo_q;
  assign bus.iter_cnt   = iter_q;

endmodule

`default_nettype wire

// File: tb/tb_maxnet_sequencer.sv
// ---------------------------------------------------------------------------
// tb_maxnet_sequencer : randomized self-checking bench for maxnet_sequencer
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_maxnet_sequencer;

  localparam int MAX_ITER = 3;

  typedef struct packed {
    logic       in_ld;
    logic       acc_clr;
    logic       acc_en;
    logic [3:0] w_addr;
    logic [1:0] x_sel;
    logic [3:0] res_ld;
    logic       commit;
    logic       busy;
    logic       done;
    logic [1:0] winner;
    logic       vld;
    logic       tmo;
    logic [3:0] iter;
  } rec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  maxnet_sequencer_if #(.ITER_W(4)) bus ();

  maxnet_sequencer #(
    .N        (4),
    .MAX_ITER (MAX_ITER),
    .ITER_W   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rec_t sample();
    rec_t a;
    a.in_ld   = bus.in_ld;
    a.acc_clr = bus.acc_clr;
    a.acc_en  = bus.acc_en;
    a.w_addr  = bus.w_addr;
    a.x_sel   = bus.x_sel;
    a.res_ld  = bus.res_ld;
    a.commit  = bus.commit;
    a.busy    = bus.busy;
    a.done    = bus.done;
    a.winner  = bus.winner;
    a.vld     = bus.winner_vld;
    a.tmo     = bus.timeout;
    a.iter    = bus.iter_cnt;
    return a;
  endfunction

  // Expected per-cycle trace of one run: LOAD, then CHECK / iteration bodies, DONE, IDLE
  task automatic build(input logic [3:0] fl[$], output rec_t q[$], output logic [3:0] drv[$]);
    rec_t       r;
    int         iter;
    int         k;
    int         p;
    logic [3:0] f;
    logic [1:0] w;
    q = {};
    drv = {};
    iter = 0;
    k = 0;
    r = '0;
    r.busy = 1'b1;
    r.in_ld = 1'b1;
    q.push_back(r); drv.push_back(4'($urandom));
    forever begin
      f = (k < fl.size()) ? fl[k] : 4'b1111;
      r = '0; r.busy = 1'b1; r.iter = 4'(iter);
      q.push_back(r); drv.push_back(f);
      p = $countones(f);
      if (p <= 1 || iter == MAX_ITER) begin
        w = 2'd0;
        for (int b = 0; b < 4; b++) if (p == 1 && f[b]) w = 2'(b);
        r.done = 1'b1;
        r.winner = w;
        r.vld = (p == 1);
        r.tmo = (p > 1);
        q.push_back(r); drv.push_back(4'($urandom));
        r.busy = 1'b0; r.done = 1'b0;
        q.push_back(r); drv.push_back(4'($urandom));
        break;
      end
      for (int row = 0; row < 4; row++) begin
        r = '0; r.busy = 1'b1; r.iter = 4'(iter); r.acc_clr = 1'b1;
        q.push_back(r); drv.push_back(4'($urandom));
        for (int col = 0; col < 4; col++) begin
          r = '0; r.busy = 1'b1; r.iter = 4'(iter); r.acc_en = 1'b1;
          r.w_addr = 4'(row * 4 + col);
          r.x_sel = 2'(col);
          q.push_back(r); drv.push_back(4'($urandom));
        end
        r = '0; r.busy = 1'b1; r.iter = 4'(iter); r.res_ld = 4'(1 << row);
        q.push_back(r); drv.push_back(4'($urandom));
      end
      r = '0; r.busy = 1'b1; r.iter = 4'(iter); r.commit = 1'b1;
      q.push_back(r); drv.push_back(4'($urandom));
      iter++;
      k++;
    end
  endtask

  // Starts from IDLE; checks every cycle of the run through the IDLE cycle after DONE
  task automatic run(input logic [3:0] fl[$], input bit hold, input bit rnd_start, input string nm);
    rec_t       q[$];
    logic [3:0] drv[$];
    rec_t       a;
    build(fl, q, drv);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = hold;
    for (int i = 0; i < q.size(); i++) begin
      a = sample();
      total++;
      if (a !== q[i]) begin
        bad++;
        $display("FAIL %s cycle %0d: got %h want %h", nm, i + 1, a, q[i]);
      end
      bus.pos_flags = drv[i];
      if (!hold) bus.start = (rnd_start && i != q.size() - 1) ? 1'($urandom) : 1'b0;
      if (i != q.size() - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rec_t a;
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.pos_flags = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      a = sample();
      total++;
      if (a !== rec_t'(0)) begin
        bad++;
        $display("FAIL reset_hold: got %h want 0", a);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    total++;
    if (bus.in_ld !== 1'b1 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_start: in_ld=%b busy=%b want 1 1", bus.in_ld, bus.busy);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_drain_idle: busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_immediate_winner();
    run('{4'b0100}, 1'b0, 1'b0, "immediate_winner");
  endtask

  task automatic test_one_iteration();
    run('{4'b1111, 4'b0001}, 1'b0, 1'b0, "one_iteration");
  endtask

  task automatic test_timeout();
    run('{4'b1111, 4'b1111, 4'b1111, 4'b1111}, 1'b0, 1'b0, "timeout");
  endtask

  task automatic test_no_survivor();
    run('{4'b0000}, 1'b0, 1'b0, "no_survivor");
  endtask

  task automatic test_random();
    logic [3:0] fl[$];
    logic [3:0] f;
    int         n;
    for (int t = 0; t < 12; t++) begin
      fl = {};
      n = $urandom_range(0, 4);
      for (int j = 0; j < n; j++) begin
        do f = 4'($urandom); while ($countones(f) < 2);
        fl.push_back(f);
      end
      fl.push_back(4'($urandom));
      run(fl, 1'b0, 1'b1, "random_run");
    end
  endtask

  task automatic test_back_to_back();
    run('{4'b1010, 4'b1000}, 1'b1, 1'b0, "back_to_back_a");
    run('{4'b0010}, 1'b1, 1'b0, "back_to_back_b");
    bus.start = 1'b0;
    run('{4'b0000}, 1'b0, 1'b0, "back_to_back_c");
  endtask

  task automatic test_mid_reset();
    rec_t a;
    int   m;
    m = $urandom_range(3, 6);
    bus.pos_flags = 4'b1111;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < m; i++) begin
      bus.pos_flags = 4'b1111;
      @(posedge clk); #1;
    end
    total++;
    if (bus.acc_en !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_in_mac: acc_en=%b want 1", bus.acc_en);
    end
    rst_n = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.start = 1'b0;
    a = sample();
    total++;
    if (a !== rec_t'(0)) begin
      bad++;
      $display("FAIL mid_reset_clear: got %h want 0", a);
    end
    @(posedge clk); #1;
    a = sample();
    total++;
    if (a !== rec_t'(0)) begin
      bad++;
      $display("FAIL mid_reset_stays_idle: got %h want 0", a);
    end
    run('{4'b0111, 4'b1100, 4'b0100}, 1'b0, 1'b1, "after_mid_reset");
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.pos_flags = 4'b0000;
    test_reset();
    test_immediate_winner();
    test_one_iteration();
    test_timeout();
    test_no_survivor();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
